// File: rtl/wbi_res_lock_arb_if.sv
// wbi_res_lock_arb_if: response-path request/grant bundle between N requesters and the lock arbiter.
interface wbi_res_lock_arb_if #(
    parameter int N  = 2,
    parameter int NW = 1,
    parameter int CW = 9
);
    logic [N-1:0]  req_i;
    logic [N-1:0]  lack_i;
    logic          rrdy_i;
    logic [N-1:0]  rrdy_o;
    logic [NW-1:0] gnt_o;
    logic          gnt_val_o;
    logic          lock_o;
    logic [CW-1:0] beat_cnt_o;
    logic          burst_err_o;

    modport master (
        output req_i, lack_i, rrdy_i,
        input  rrdy_o, gnt_o, gnt_val_o, lock_o, beat_cnt_o, burst_err_o
    );

    modport slave (
        input  req_i, lack_i, rrdy_i,
        output rrdy_o, gnt_o, gnt_val_o, lock_o, beat_cnt_o, burst_err_o
    );
endinterface

// File: rtl/wbi_res_lock_arb.sv
// wbi_res_lock_arb: round-robin response arbiter that holds a grant for the whole burst.
module wbi_res_lock_arb #(
    parameter int N    = 2,
    parameter int NW   = (N > 1) ? $clog2(N) : 1,
    parameter int MAXB = 256,
    parameter int CW   = $clog2(MAXB + 1)
) (
    input logic                 mclk,
    input logic                 reset_n,
    wbi_res_lock_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ARMED, BURST} state_t;

    state_t        r_state, w_state_nxt;
    logic [NW-1:0] r_gnt, w_gnt_nxt, r_ptr, w_ptr_nxt;
    logic          r_gnt_val, w_gnt_val_nxt, r_err, w_err_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_xfer, w_last, w_rel, w_any;

    // First requester strictly after p, wrapping; p itself is considered last.
    function automatic logic [NW-1:0] rr_pick(input logic [N-1:0] req, input logic [NW-1:0] p);
        logic [NW-1:0] g;
        g = p;
        for (int k = N; k >= 1; k--)
            if (req[(int'(p) + k) % N]) g = NW'((int'(p) + k) % N);
        return g;
    endfunction

    assign w_any  = |bus.req_i;
    assign w_xfer = r_gnt_val & bus.req_i[r_gnt] & bus.rrdy_i;
    assign w_last = w_xfer & bus.lack_i[r_gnt];

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_val <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_ptr     <= NW'(N - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_val <= w_gnt_val_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_val_nxt = r_gnt_val;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_rel         = 1'b0;
        unique case (r_state)
            IDLE: if (w_any) begin
                w_state_nxt   = ARMED;
                w_gnt_nxt     = rr_pick(bus.req_i, r_ptr);
                w_gnt_val_nxt = 1'b1;
            end
            ARMED: if (w_last || !bus.req_i[r_gnt]) w_rel = 1'b1;
                   else if (w_xfer) begin
                       w_state_nxt = BURST;
                       w_cnt_nxt   = CW'(1);
                   end
            BURST: if (w_last) w_rel = 1'b1;
                   else if (w_xfer && r_cnt == CW'(MAXB - 1)) begin
                       w_rel     = 1'b1;
                       w_err_nxt = 1'b1;
                   end else if (w_xfer)
                       w_cnt_nxt = (r_cnt < CW'(MAXB)) ? r_cnt + CW'(1) : r_cnt;
            default: w_state_nxt = IDLE;
        endcase
        // Release re-arbitrates on the same edge so back-to-back grants have no bubble.
        if (w_rel) begin
            w_ptr_nxt     = r_gnt;
            w_cnt_nxt     = '0;
            w_state_nxt   = w_any ? ARMED : IDLE;
            w_gnt_val_nxt = w_any;
            w_gnt_nxt     = w_any ? rr_pick(bus.req_i, r_gnt) : r_gnt;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rrdy
        assign bus.rrdy_o[i] = bus.rrdy_i & r_gnt_val & (r_gnt == NW'(i));
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_val_o   = r_gnt_val;
    assign bus.lock_o      = (r_state == BURST);
    assign bus.beat_cnt_o  = r_cnt;
    assign bus.burst_err_o = r_err;
endmodule

// File: tb/tb_wbi_res_lock_arb.sv
// tb_wbi_res_lock_arb: directed stimulus with a beat scoreboard checked by an independent monitor.
module tb_wbi_res_lock_arb;
    localparam int N = 2, NW = 1, MAXB = 4, CW = 3;

    typedef struct packed {
        logic [NW-1:0] gnt;
        logic          lock;
        logic [CW-1:0] cnt;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    total = 0;
    int    bad = 0;
    beat_t sb[$];

    wbi_res_lock_arb_if #(.N(N), .NW(NW), .CW(CW)) bus();

    wbi_res_lock_arb #(.N(N), .NW(NW), .MAXB(MAXB), .CW(CW)) dut (
        .mclk(clk), .reset_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] lack, input logic rdy);
        bus.req_i = req; bus.lack_i = lack; bus.rrdy_i = rdy;
        @(posedge clk); #1;
    endtask

    task automatic push(input int g, input int lk, input int c);
        beat_t b;
        b.gnt = NW'(g); b.lock = lk[0]; b.cnt = CW'(c);
        sb.push_back(b);
    endtask

    task automatic do_reset();
        bus.req_i = '0; bus.lack_i = '0; bus.rrdy_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Every accepted beat must match the next expected beat, in order.
    always @(negedge clk) begin
        if (rst_n && bus.gnt_val_o && bus.req_i[bus.gnt_o] && bus.rrdy_i) begin
            if (sb.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_gnt", int'(bus.gnt_o), int'(e.gnt));
                chk("beat_lock", int'(bus.lock_o), int'(e.lock));
                chk("beat_cnt", int'(bus.beat_cnt_o), int'(e.cnt));
                chk("beat_rrdy", int'(bus.rrdy_o), e.gnt ? 2 : 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_i = '0; bus.lack_i = '0; bus.rrdy_i = 1'b0;
        #2;
        chk("rst_gnt_val", int'(bus.gnt_val_o), 0);
        chk("rst_gnt", int'(bus.gnt_o), 0);
        chk("rst_lock", int'(bus.lock_o), 0);
        chk("rst_cnt", int'(bus.beat_cnt_o), 0);
        chk("rst_err", int'(bus.burst_err_o), 0);
        do_reset();
        // single requester, one-beat response
        step(2'b01, 2'b00, 1);
        chk("t1_gnt_val", int'(bus.gnt_val_o), 1);
        chk("t1_gnt", int'(bus.gnt_o), 0);
        chk("t1_rrdy", int'(bus.rrdy_o), 1);
        push(0, 0, 0); step(2'b01, 2'b01, 1);
        step(2'b00, 2'b00, 1);
        chk("t1_idle", int'(bus.gnt_val_o), 0);
        // two contending one-beat requesters alternate with no gap
        do_reset();
        step(2'b11, 2'b11, 1);
        chk("t2_first", int'(bus.gnt_o), 0);
        for (int i = 0; i < 4; i++) begin
            push(i % 2, 0, 0); step(2'b11, 2'b11, 1);
            chk("t2_gnt_val", int'(bus.gnt_val_o), 1);
            chk("t2_next", int'(bus.gnt_o), (i + 1) % 2);
        end
        step(2'b00, 2'b00, 1);
        // 4-beat locked burst from 0 while 1 waits, with one backpressure cycle
        do_reset();
        step(2'b01, 2'b00, 1);
        push(0, 0, 0); step(2'b01, 2'b00, 1);
        push(0, 1, 1); step(2'b11, 2'b00, 1);
        step(2'b11, 2'b00, 0);
        chk("t3_bp_gnt", int'(bus.gnt_o), 0);
        chk("t3_bp_cnt", int'(bus.beat_cnt_o), 2);
        push(0, 1, 2); step(2'b11, 2'b00, 1);
        push(0, 1, 3); step(2'b11, 2'b01, 1);
        chk("t3_gnt1", int'(bus.gnt_o), 1);
        chk("t3_unlock", int'(bus.lock_o), 0);
        chk("t3_no_err", int'(bus.burst_err_o), 0);
        push(1, 0, 0); step(2'b10, 2'b10, 1);
        step(2'b00, 2'b00, 1);
        // owner stalls mid-burst; grant held and the other requester is not served
        do_reset();
        step(2'b01, 2'b00, 1);
        push(0, 0, 0); step(2'b01, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 2'b00, 1);
            chk("t4_hold_gnt", int'(bus.gnt_o), 0);
            chk("t4_hold_lock", int'(bus.lock_o), 1);
            chk("t4_rrdy", int'(bus.rrdy_o), 1);
        end
        push(0, 1, 1); step(2'b11, 2'b00, 1);
        push(0, 1, 2); step(2'b11, 2'b01, 1);
        chk("t4_gnt1", int'(bus.gnt_o), 1);
        push(1, 0, 0); step(2'b10, 2'b10, 1);
        step(2'b00, 2'b00, 1);
        // burst with no lack is cut at MAXB beats
        do_reset();
        step(2'b01, 2'b00, 1);
        push(0, 0, 0); step(2'b11, 2'b00, 1);
        push(0, 1, 1); step(2'b11, 2'b00, 1);
        push(0, 1, 2); step(2'b11, 2'b00, 1);
        chk("t5_pre_err", int'(bus.burst_err_o), 0);
        push(0, 1, 3); step(2'b11, 2'b00, 1);
        chk("t5_err", int'(bus.burst_err_o), 1);
        chk("t5_gnt1", int'(bus.gnt_o), 1);
        chk("t5_cnt0", int'(bus.beat_cnt_o), 0);
        chk("t5_unlock", int'(bus.lock_o), 0);
        push(1, 0, 0); step(2'b10, 2'b10, 1);
        chk("t5_err_pulse", int'(bus.burst_err_o), 0);
        step(2'b00, 2'b00, 1);
        // asynchronous reset in the middle of a burst
        do_reset();
        step(2'b01, 2'b00, 1);
        push(0, 0, 0); step(2'b01, 2'b00, 1);
        push(0, 1, 1); step(2'b01, 2'b00, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_val", int'(bus.gnt_val_o), 0);
        chk("t6_lock", int'(bus.lock_o), 0);
        chk("t6_cnt", int'(bus.beat_cnt_o), 0);
        chk("t6_rrdy", int'(bus.rrdy_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(2'b11, 2'b11, 1);
        chk("t6_first", int'(bus.gnt_o), 0);
        push(0, 0, 0); step(2'b11, 2'b11, 1);
        step(2'b00, 2'b00, 1);
        repeat (3) step(2'b00, 2'b00, 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
